// File: rtl/change_dispenser_pkg.sv
// Shared coin definitions for the change dispenser: coin values, eject bit
// positions, FSM state encoding and the greedy coin picker.
package change_dispenser_pkg;

  localparam int EJECT_W = 4;

  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;
  localparam int DOLLAR_V  = 20;

  // eject = {Nickel, Dime, Quarter, Dollar}
  localparam int DOLLAR_BIT  = 0;
  localparam int QUARTER_BIT = 1;
  localparam int DIME_BIT    = 2;
  localparam int NICKEL_BIT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Largest coin not exceeding rem, one-hot on the eject bits; zero if rem==0.
  function automatic logic [EJECT_W-1:0] greedy_pick(input logic [31:0] rem);
    logic [EJECT_W-1:0] sel;
    sel = '0;
    if (rem >= 32'(DOLLAR_V))       sel[DOLLAR_BIT]  = 1'b1;
    else if (rem >= 32'(QUARTER_V)) sel[QUARTER_BIT] = 1'b1;
    else if (rem >= 32'(DIME_V))    sel[DIME_BIT]    = 1'b1;
    else if (rem >= 32'(NICKEL_V))  sel[NICKEL_BIT]  = 1'b1;
    return sel;
  endfunction

  function automatic logic [31:0] coin_value(input logic [EJECT_W-1:0] sel);
    logic [31:0] val;
    val = '0;
    if (sel[DOLLAR_BIT])  val = 32'(DOLLAR_V);
    if (sel[QUARTER_BIT]) val = 32'(QUARTER_V);
    if (sel[DIME_BIT])    val = 32'(DIME_V);
    if (sel[NICKEL_BIT])  val = 32'(NICKEL_V);
    return val;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser signal bundle.
// start is a level request accepted only while the dispenser is idle; there is
// no ready: busy rises the cycle after acceptance and done pulses once at the end.
interface change_dispenser_if #(
  parameter int AMT_W = 6
);
  import change_dispenser_pkg::*;

  logic               start;
  logic [AMT_W-1:0]   amount;
  logic               inhibit;
  logic [EJECT_W-1:0] eject;
  logic               busy;
  logic               done;
  logic [AMT_W-1:0]   remaining;

  modport master (
    output start, amount, inhibit,
    input  eject, busy, done, remaining
  );

  modport slave (
    input  start, amount, inhibit,
    output eject, busy, done, remaining
  );
endinterface

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter timing both the eject pulse and the following gap.
module change_dispenser_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a nickel-unit amount as one eject pulse per coin,
// largest coin first, with a fixed pulse width and gap between coins.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W        = 6,
  parameter int PULSE_CYCLES = 50,
  parameter int GAP_CYCLES   = 50
) (
  input  logic             clk,
  input  logic             rst,
  change_dispenser_if.slave bus,
  output state_t           state_dbg
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t             state;
  logic [EJECT_W-1:0] eject_q;
  logic               busy_q;
  logic               done_q;
  logic [AMT_W-1:0]   remaining_q;

  logic [EJECT_W-1:0] coin_sel;
  logic [AMT_W-1:0]   coin_val;
  logic               t_load;
  logic [TW-1:0]      t_load_val;
  logic               t_zero;
  logic               fire;

  always_comb begin
    coin_sel = greedy_pick(32'(remaining_q));
    coin_val = AMT_W'(coin_value(coin_sel));
  end

  // A coin is launched only from SELECT with something owed and the mechanism ready.
  assign fire = (state == ST_SELECT) && (remaining_q != '0) && !bus.inhibit;

  always_comb begin
    t_load     = 1'b0;
    t_load_val = TW'(PULSE_CYCLES - 1);
    if (fire) begin
      t_load     = 1'b1;
      t_load_val = TW'(PULSE_CYCLES - 1);
    end else if (state == ST_PULSE && t_zero) begin
      t_load     = 1'b1;
      t_load_val = TW'(GAP_CYCLES - 1);
    end
  end

  change_dispenser_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      eject_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            remaining_q <= bus.amount;
            busy_q      <= 1'b1;
            state       <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining_q == '0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_FINISH;
          end else if (fire) begin
            eject_q     <= coin_sel;
            remaining_q <= remaining_q - coin_val;
            state       <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (t_zero) begin
            eject_q <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (t_zero) state <= ST_SELECT;
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          eject_q <= '0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.eject     = eject_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payouts plus hand-written
// reset-mid-pulse and minimum-timing sequences.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int AMT_W   = 6;
  localparam int PULSE   = 50;
  localparam int GAP     = 50;
  localparam int PERIOD  = 1 + PULSE + GAP;
  localparam int LAT_MAX = 1000;

  localparam logic [3:0] C_DOL = 4'b0001;
  localparam logic [3:0] C_QTR = 4'b0010;
  localparam logic [3:0] C_DIM = 4'b0100;
  localparam logic [3:0] C_NIC = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();
  change_dispenser_if #(.AMT_W(AMT_W)) fbus ();
  state_t st;
  state_t fst;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (st)
  );

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .bus       (fbus),
    .state_dbg (fst)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Invariants sampled every cycle away from the active edge.
  logic       busy_prev = 1'b0;
  logic [5:0] rem_prev  = '0;
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      check("onehot0_eject", int'($onehot0(bus.eject)), 1);
      check("onehot0_eject_fast", int'($onehot0(fbus.eject)), 1);
      check("busy_with_done", int'(bus.busy && bus.done), 0);
      if (busy_prev && bus.busy)
        check("remaining_nonincreasing", int'(bus.remaining <= rem_prev), 1);
      busy_prev = bus.busy;
      rem_prev  = bus.remaining;
    end
  end

  // ---------------- vector table ----------------
  // coins/rems: element 0 (rightmost) is the first coin paid.
  typedef struct {
    logic [5:0]      amount;
    int              inh;
    bit              restart;
    int              n;
    logic [7:0][3:0] coins;
    logic [7:0][5:0] rems;
    int              done_lat;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver ----------------
  // Latency lat = observed at the negedge after accept edge N + (lat-1).
  task automatic run_vec(input vec_t v, input string tag);
    int done_lat = 0;
    int n_seen = 0;
    int prev_rise = 0;
    int hi_cnt = 0;
    logic [3:0] prev_ej = '0;
    logic [9:0] e;
    exp_q.delete();
    for (int i = 0; i < v.n; i++) exp_q.push_back({v.coins[i], v.rems[i]});
    @(negedge clk);
    bus.amount  = v.amount;
    bus.start   = 1'b1;
    bus.inhibit = (v.inh > 0);
    @(posedge clk);
    for (int lat = 1; lat <= LAT_MAX && done_lat == 0; lat++) begin
      @(negedge clk);
      if (lat == 1) check({tag, " busy_after_accept"}, int'(bus.busy), 1);
      if (bus.eject != '0 && prev_ej == '0) begin
        if (n_seen == 0) check({tag, " first_eject_lat"}, lat, 2 + v.inh);
        else             check({tag, " coin_period"}, lat - prev_rise, PERIOD);
        prev_rise = lat;
        hi_cnt    = 0;
        n_seen++;
        if (exp_q.size() == 0) begin
          check({tag, " coin_overrun"}, n_seen, v.n);
        end else begin
          e = exp_q.pop_front();
          check({tag, " coin"}, int'(bus.eject), int'(e[9:6]));
          check({tag, " remaining"}, int'(bus.remaining), int'(e[5:0]));
        end
      end
      if (bus.eject != '0) hi_cnt++;
      if (bus.eject == '0 && prev_ej != '0) check({tag, " pulse_width"}, hi_cnt, PULSE);
      if (bus.done) done_lat = lat;
      prev_ej = bus.eject;
      if (lat == 1) bus.start = 1'b0;
      if (v.inh > 0 && lat == v.inh + 1) bus.inhibit = 1'b0;
      if (v.restart && lat == 60) begin
        bus.start  = 1'b1;
        bus.amount = 6'd5;
      end
      if (v.restart && lat == 61) bus.start = 1'b0;
    end
    bus.start   = 1'b0;
    bus.inhibit = 1'b0;
    check({tag, " done_lat"}, done_lat, v.done_lat);
    check({tag, " coin_count"}, n_seen, v.n);
    check({tag, " final_remaining"}, int'(bus.remaining), 0);
    check({tag, " pending_coins"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, " idle_busy"}, int'(bus.busy), 0);
    check({tag, " idle_done"}, int'(bus.done), 0);
    check({tag, " idle_state"}, int'(st), int'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t t;
    int rise;
    int dlat;
    int hi;
    logic [3:0] coin;

    bus.start = 1'b0;  bus.amount = '0;  bus.inhibit = 1'b0;
    fbus.start = 1'b0; fbus.amount = '0; fbus.inhibit = 1'b0;

    vecs[0] = '{amount: 6'd38, inh: 0, restart: 1'b0, n: 6,
                coins: {4'd0, 4'd0, C_NIC, C_DIM, C_QTR, C_QTR, C_QTR, C_DOL},
                rems:  {6'd0, 6'd0, 6'd0, 6'd1, 6'd3, 6'd8, 6'd13, 6'd18},
                done_lat: 6 * PERIOD + 2};
    vecs[1] = '{amount: 6'd0, inh: 0, restart: 1'b0, n: 0,
                coins: '0, rems: '0, done_lat: 2};
    vecs[2] = '{amount: 6'd7, inh: 30, restart: 1'b0, n: 2,
                coins: {24'd0, C_DIM, C_QTR},
                rems:  {36'd0, 6'd0, 6'd2},
                done_lat: 2 + 30 + 2 * PERIOD};
    vecs[3] = '{amount: 6'd63, inh: 0, restart: 1'b1, n: 5,
                coins: {12'd0, C_NIC, C_DIM, C_DOL, C_DOL, C_DOL},
                rems:  {18'd0, 6'd0, 6'd1, 6'd3, 6'd23, 6'd43},
                done_lat: 5 * PERIOD + 2};
    vecs[4] = '{amount: 6'd24, inh: 0, restart: 1'b0, n: 3,
                coins: {20'd0, C_DIM, C_DIM, C_DOL},
                rems:  {30'd0, 6'd0, 6'd2, 6'd4},
                done_lat: 3 * PERIOD + 2};

    repeat (3) @(negedge clk);
    check("reset_eject_in_reset", int'(bus.eject), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_eject", int'(bus.eject), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_remaining", int'(bus.remaining), 0);
    check("reset_state", int'(st), int'(ST_IDLE));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of the first Dollar pulse of a 25-nickel payout.
    @(negedge clk);
    bus.amount = 6'd25;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10 && bus.eject == '0; k++) @(negedge clk);
    check("rst_mid first_coin", int'(bus.eject), int'(C_DOL));
    check("rst_mid first_remaining", int'(bus.remaining), 5);
    repeat (20) @(negedge clk);
    check("rst_mid still_pulsing", int'(bus.eject), int'(C_DOL));
    rst = 1'b1;
    #1;
    check("rst_mid eject_async", int'(bus.eject), 0);
    check("rst_mid busy_async", int'(bus.busy), 0);
    check("rst_mid remaining_async", int'(bus.remaining), 0);
    check("rst_mid state_async", int'(st), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    t = '{amount: 6'd1, inh: 0, restart: 1'b0, n: 1,
          coins: {28'd0, C_NIC}, rems: '0, done_lat: PERIOD + 2};
    run_vec(t, "after_rst");

    // Minimum timing instance: 1-clock pulse, 1-clock gap.
    @(negedge clk);
    fbus.amount = 6'd20;
    fbus.start  = 1'b1;
    @(posedge clk);
    rise = 0; dlat = 0; hi = 0; coin = '0;
    for (int lat = 1; lat <= 20 && dlat == 0; lat++) begin
      @(negedge clk);
      if (fbus.eject != '0) begin
        if (rise == 0) begin
          rise = lat;
          coin = fbus.eject;
        end
        hi++;
      end
      if (fbus.done) dlat = lat;
      if (lat == 1) fbus.start = 1'b0;
    end
    fbus.start = 1'b0;
    check("fast first_eject_lat", rise, 2);
    check("fast coin", int'(coin), int'(C_DOL));
    check("fast pulse_width", hi, 1);
    check("fast pulse_to_done", dlat - rise, 3);
    check("fast final_remaining", int'(fbus.remaining), 0);
    @(negedge clk);
    check("fast idle_state", int'(fst), int'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
